// File: rtl/sb_pkg.sv
// Shared types and sizes for the store buffer: entry layout and drain FSM states.
`timescale 1ns/1ps
package sb_pkg;

  localparam int SB_DEPTH = 8;
  localparam int SB_IDX_W = 3;
  localparam int SB_CNT_W = SB_IDX_W + 1;
  localparam int AW       = 32;
  localparam int DW       = 32;

  typedef struct packed {
    logic          valid;
    logic          addr_v;
    logic          cmt;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_t;

endpackage

// File: rtl/sb_drain_fsm.sv
// Drain controller: issues the head entry to memory and pulses free_head when it is accepted.
`timescale 1ns/1ps
module sb_drain_fsm
  import sb_pkg::*;
(
  input  logic          clk1,
  input  logic          reset,
  input  logic          head_ready,
  input  logic [AW-1:0] head_addr,
  input  logic [DW-1:0] head_data,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          free_head,
  output drain_state_t  state
);

  // Handshake: mem_req rises with mem_addr/mem_data and all three hold until a cycle
  // with mem_ack=1; that cycle completes the write. mem_ack while idle is ignored.
  drain_state_t  state_n;
  logic          req_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] data_n;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      state    <= state_n;
      mem_req  <= req_n;
      mem_addr <= addr_n;
      mem_data <= data_n;
    end
  end

  always_comb begin
    state_n   = state;
    req_n     = mem_req;
    addr_n    = mem_addr;
    data_n    = mem_data;
    free_head = 1'b0;
    case (state)
      IDLE: begin
        if (head_ready) begin
          addr_n  = head_addr;
          data_n  = head_data;
          req_n   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          req_n     = 1'b0;
          free_head = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/store_buffer_drain.sv
// Circular store buffer: dual allocation, AGU fill, commit marking, flush recovery and
// in-order drain of committed stores to data memory.
`timescale 1ns/1ps
module store_buffer_drain
  import sb_pkg::*;
(
  input  logic                clk1,
  input  logic                reset,
  input  logic                alloc1_en,
  input  logic                alloc2_en,
  output logic [SB_IDX_W-1:0] alloc1_idx,
  output logic [SB_IDX_W-1:0] alloc2_idx,
  output logic                sb_full,
  output logic                sb_empty,
  input  logic                agu_wen,
  input  logic [SB_IDX_W-1:0] agu_idx,
  input  logic [AW-1:0]       agu_addr,
  input  logic [DW-1:0]       agu_data,
  input  logic                cmt1_en,
  input  logic [SB_IDX_W-1:0] cmt1_idx,
  input  logic                cmt2_en,
  input  logic [SB_IDX_W-1:0] cmt2_idx,
  input  logic                flush,
  output logic                mem_req,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_data,
  input  logic                mem_ack,
  output drain_state_t        drain_state
);

  sb_entry_t           ent   [SB_DEPTH];
  sb_entry_t           ent_n [SB_DEPTH];
  sb_entry_t           head_ent;
  logic [SB_IDX_W-1:0] head, head_n, tail, tail_n, scan_idx;
  logic [SB_CNT_W-1:0] count, count_n, ncmt;
  logic [1:0]          nalloc;
  logic                run, do_alloc, head_ready, free_head;

  assign alloc1_idx = tail;
  assign alloc2_idx = alloc1_en ? tail + 1'b1 : tail;
  assign sb_full    = count > SB_CNT_W'(SB_DEPTH - 2);
  assign sb_empty   = (count == '0);
  assign nalloc     = {1'b0, alloc1_en} + {1'b0, alloc2_en};
  assign do_alloc   = !sb_full && !flush;
  assign head_ent   = ent[head];

  // Same-cycle commits count toward readiness so a ready head issues one cycle after commit.
  assign head_ready = head_ent.valid && head_ent.addr_v &&
                      (head_ent.cmt || (cmt1_en && cmt1_idx == head) ||
                       (cmt2_en && cmt2_idx == head));

  sb_drain_fsm u_drain (
    .clk1       (clk1),
    .reset      (reset),
    .head_ready (head_ready),
    .head_addr  (head_ent.addr),
    .head_data  (head_ent.data),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .free_head  (free_head),
    .state      (drain_state)
  );

  always_comb begin
    ent_n    = ent;
    head_n   = head;
    tail_n   = tail;
    count_n  = count;
    ncmt     = '0;
    run      = 1'b1;
    scan_idx = '0;

    if (cmt1_en) ent_n[cmt1_idx].cmt = 1'b1;
    if (cmt2_en) ent_n[cmt2_idx].cmt = 1'b1;
    if (agu_wen && ent[agu_idx].valid) begin
      ent_n[agu_idx].addr   = agu_addr;
      ent_n[agu_idx].data   = agu_data;
      ent_n[agu_idx].addr_v = 1'b1;
    end

    // Length of the committed run from head, seen after this cycle's commits.
    for (int i = 0; i < SB_DEPTH; i++) begin
      scan_idx = head + SB_IDX_W'(i);
      if (run && (SB_CNT_W'(i) < count) && ent_n[scan_idx].valid && ent_n[scan_idx].cmt)
        ncmt = ncmt + 1'b1;
      else
        run = 1'b0;
    end

    if (free_head) begin
      ent_n[head].valid  = 1'b0;
      ent_n[head].addr_v = 1'b0;
      ent_n[head].cmt    = 1'b0;
      head_n             = head + 1'b1;
    end

    if (flush) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (!ent_n[i].cmt) begin
          ent_n[i].valid  = 1'b0;
          ent_n[i].addr_v = 1'b0;
        end
      end
      tail_n  = head + ncmt[SB_IDX_W-1:0];
      count_n = ncmt - SB_CNT_W'(free_head);
    end else if (do_alloc) begin
      if (alloc1_en) begin
        ent_n[tail].valid  = 1'b1;
        ent_n[tail].addr_v = 1'b0;
        ent_n[tail].cmt    = 1'b0;
      end
      if (alloc2_en) begin
        ent_n[alloc2_idx].valid  = 1'b1;
        ent_n[alloc2_idx].addr_v = 1'b0;
        ent_n[alloc2_idx].cmt    = 1'b0;
      end
      tail_n  = tail + SB_IDX_W'(nalloc);
      count_n = count + SB_CNT_W'(nalloc) - SB_CNT_W'(free_head);
    end else begin
      count_n = count - SB_CNT_W'(free_head);
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) ent[i] <= '0;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
      for (int i = 0; i < SB_DEPTH; i++) ent[i] <= ent_n[i];
    end
  end

  // Dispatch must stall on sb_full; a request made anyway is dropped by do_alloc.
  assert property (@(posedge clk1) disable iff (reset) sb_full |-> !(alloc1_en || alloc2_en));

endmodule

// File: tb/tb_store_buffer_drain.sv
// Directed bench for store_buffer_drain with a drain-order scoreboard.
`timescale 1ns/1ps
module tb_store_buffer_drain;
  import sb_pkg::*;

  logic                clk1, reset;
  logic                alloc1_en, alloc2_en;
  logic [SB_IDX_W-1:0] alloc1_idx, alloc2_idx;
  logic                sb_full, sb_empty;
  logic                agu_wen;
  logic [SB_IDX_W-1:0] agu_idx;
  logic [AW-1:0]       agu_addr;
  logic [DW-1:0]       agu_data;
  logic                cmt1_en, cmt2_en;
  logic [SB_IDX_W-1:0] cmt1_idx, cmt2_idx;
  logic                flush;
  logic                mem_req;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_data;
  logic                mem_ack;
  drain_state_t        drain_state;

  logic [AW+DW-1:0] exp_q[$];
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  store_buffer_drain dut (
    .clk1(clk1), .reset(reset),
    .alloc1_en(alloc1_en), .alloc2_en(alloc2_en),
    .alloc1_idx(alloc1_idx), .alloc2_idx(alloc2_idx),
    .sb_full(sb_full), .sb_empty(sb_empty),
    .agu_wen(agu_wen), .agu_idx(agu_idx), .agu_addr(agu_addr), .agu_data(agu_data),
    .cmt1_en(cmt1_en), .cmt1_idx(cmt1_idx), .cmt2_en(cmt2_en), .cmt2_idx(cmt2_idx),
    .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .drain_state(drain_state)
  );

  // Clock and reset
  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp_v);
    n_total++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Driver tasks
  task automatic do_alloc(input string tag, input bit a1, input bit a2,
                          input logic [SB_IDX_W-1:0] e1, input logic [SB_IDX_W-1:0] e2);
    alloc1_en = a1;
    alloc2_en = a2;
    #1;
    if (a1) check({tag, "_idx1"}, 72'(alloc1_idx), 72'(e1));
    if (a2) check({tag, "_idx2"}, 72'(alloc2_idx), 72'(e2));
    tick();
    alloc1_en = 1'b0;
    alloc2_en = 1'b0;
  endtask

  task automatic agu(input logic [SB_IDX_W-1:0] idx, input bit push);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = $urandom();
    d = $urandom_range(1, 32'h7fff_ffff);
    agu_wen  = 1'b1;
    agu_idx  = idx;
    agu_addr = a;
    agu_data = d;
    if (push) exp_q.push_back({a, d});
    tick();
    agu_wen = 1'b0;
  endtask

  task automatic commit(input bit e1, input logic [SB_IDX_W-1:0] i1,
                        input bit e2, input logic [SB_IDX_W-1:0] i2);
    cmt1_en  = e1;
    cmt1_idx = i1;
    cmt2_en  = e2;
    cmt2_idx = i2;
    tick();
    cmt1_en = 1'b0;
    cmt2_en = 1'b0;
  endtask

  // Scoreboard: wait for a request, compare with the oldest expected store, hold, then ack.
  task automatic drain_one(input string tag, input int hold, input bit flush_mid);
    logic [AW+DW-1:0] exp_v;
    int waited;
    waited = 0;
    while (!mem_req && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_req"}, 72'(mem_req), 72'(1));
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_addr"}, 72'(mem_addr), 72'(exp_v[AW+DW-1:DW]));
    check({tag, "_data"}, 72'(mem_data), 72'(exp_v[DW-1:0]));
    if (!mem_req) return;
    for (int i = 0; i < hold; i++) begin
      if (flush_mid && i == hold / 2) flush = 1'b1;
      tick();
      flush = 1'b0;
      check({tag, "_hold"}, 72'({mem_req, mem_addr, mem_data}), 72'({1'b1, exp_v}));
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check({tag, "_ack_clear"}, 72'(mem_req), 72'(0));
  endtask

  initial begin
    reset = 1'b1;
    alloc1_en = 0; alloc2_en = 0; agu_wen = 0; agu_idx = '0; agu_addr = '0; agu_data = '0;
    cmt1_en = 0; cmt1_idx = '0; cmt2_en = 0; cmt2_idx = '0; flush = 0; mem_ack = 0;
    repeat (2) tick();
    check("rst_req", 72'(mem_req), 72'(0));
    check("rst_empty", 72'(sb_empty), 72'(1));
    check("rst_full", 72'(sb_full), 72'(0));
    check("rst_idx", 72'({alloc1_idx, alloc2_idx}), 72'(0));
    check("rst_addr", 72'({mem_addr, mem_data}), 72'(0));
    check("rst_state", 72'(drain_state), 72'(IDLE));
    reset = 1'b0;
    tick();

    // 1: basic allocate / fill / commit / drain
    do_alloc("t1_alloc", 1, 1, 3'd0, 3'd1);
    check("t1_not_empty", 72'(sb_empty), 72'(0));
    agu(3'd0, 1);
    agu(3'd1, 1);
    commit(1, 3'd0, 1, 3'd1);
    check("t1_cmt_latency", 72'(mem_req), 72'(1));
    drain_one("t1_e0", 0, 0);
    tick();
    check("t1_gap", 72'(mem_req), 72'(1));
    drain_one("t1_e1", 0, 0);
    check("t1_empty", 72'(sb_empty), 72'(1));

    // 2: full threshold
    do_alloc("t2_a", 1, 1, 3'd2, 3'd3);
    do_alloc("t2_b", 1, 1, 3'd4, 3'd5);
    do_alloc("t2_c", 1, 1, 3'd6, 3'd7);
    check("t2_six_not_full", 72'(sb_full), 72'(0));
    do_alloc("t2_d", 1, 0, 3'd0, 3'd0);
    check("t2_seven_full", 72'(sb_full), 72'(1));
    agu(3'd2, 1);
    commit(1, 3'd2, 0, 3'd0);
    drain_one("t2_drain", 0, 0);
    check("t2_full_drop", 72'(sb_full), 72'(0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t2_flush_empty", 72'(sb_empty), 72'(1));
    check("t2_flush_tail", 72'(alloc1_idx), 72'(3));

    // 3: wrap-around drain order
    do_alloc("t3_a", 1, 1, 3'd3, 3'd4);
    do_alloc("t3_b", 1, 0, 3'd5, 3'd0);
    agu(3'd3, 1); agu(3'd4, 1); agu(3'd5, 1);
    commit(1, 3'd3, 1, 3'd4);
    commit(1, 3'd5, 0, 3'd0);
    for (int i = 0; i < 3; i++) drain_one("t3_pre", 0, 0);
    do_alloc("t3_hi", 1, 1, 3'd6, 3'd7);
    do_alloc("t3_wrap", 1, 0, 3'd0, 3'd0);
    agu(3'd6, 1); agu(3'd7, 1); agu(3'd0, 1);
    commit(1, 3'd6, 1, 3'd7);
    commit(1, 3'd0, 0, 3'd0);
    drain_one("t3_e6", 0, 0);
    drain_one("t3_e7", 0, 0);
    drain_one("t3_e0", 0, 0);
    check("t3_empty", 72'(sb_empty), 72'(1));

    // 4: flush with a same-cycle commit
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_alloc("t4_a", 1, 1, 3'd0, 3'd1);
    do_alloc("t4_b", 1, 1, 3'd2, 3'd3);
    do_alloc("t4_c", 1, 0, 3'd4, 3'd0);
    commit(1, 3'd0, 1, 3'd1);
    check("t4_no_addr_req", 72'(mem_req), 72'(0));
    flush = 1'b1; cmt1_en = 1'b1; cmt1_idx = 3'd2; alloc1_en = 1'b1;
    tick();
    flush = 1'b0; cmt1_en = 1'b0; alloc1_en = 1'b0;
    check("t4_tail", 72'(alloc1_idx), 72'(3));
    agu(3'd3, 0);
    agu(3'd0, 1); agu(3'd1, 1); agu(3'd2, 1);
    for (int i = 0; i < 3; i++) drain_one("t4_d", 0, 0);
    tick(); tick();
    check("t4_no_more_req", 72'(mem_req), 72'(0));
    check("t4_count", 72'(sb_empty), 72'(1));
    do_alloc("t4_realloc", 1, 1, 3'd3, 3'd4);

    // 5: stalled ack, flush while the request is in flight
    agu(3'd3, 1);
    commit(1, 3'd3, 0, 3'd0);
    check("t5_state_req", 72'(drain_state), 72'(REQ));
    drain_one("t5_stall", 10, 1);
    check("t5_empty", 72'(sb_empty), 72'(1));
    check("t5_tail", 72'(alloc1_idx), 72'(4));

    // 6: commit before AGU, AGU to invalid entry, reset during REQ
    do_alloc("t6_a", 1, 0, 3'd4, 3'd0);
    commit(1, 3'd4, 0, 3'd0);
    tick(); tick();
    check("t6_no_addr", 72'(mem_req), 72'(0));
    agu(3'd4, 1);
    drain_one("t6_late", 0, 0);
    agu(3'd6, 0);
    tick();
    check("t6_invalid_agu", 72'({sb_empty, mem_req}), 72'(2'b10));
    do_alloc("t6_slot2", 0, 1, 3'd0, 3'd5);
    agu(3'd5, 0);
    commit(1, 3'd5, 0, 3'd0);
    check("t6_req_pre_rst", 72'(mem_req), 72'(1));
    reset = 1'b1;
    #1;
    check("t6_rst_req", 72'(mem_req), 72'(0));
    check("t6_rst_addr", 72'({mem_addr, mem_data}), 72'(0));
    check("t6_rst_empty", 72'(sb_empty), 72'(1));
    check("t6_rst_state", 72'(drain_state), 72'(IDLE));
    #2;
    reset = 1'b0;
    tick();
    check("sb_drained", 72'(exp_q.size()), 72'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
